// File: rtl/u_pcla.sv
// ---------------------------------------------------------------------------
// u_pcla -- pipelined unsigned carry-lookahead adder
//
// Splits WIDTH-bit operands into NBLK = WIDTH/BLOCK groups of BLOCK bits.
// Stage s resolves group s with a fully expanded P/G lookahead and registers
// the group carry-out for stage s+1 (staircase pipeline). Latency is NBLK
// cycles. The throughput is one result per cycle. Valid/ready on both sides,
// with bubble collapsing.
//
// Optional feature: define U_PCLA_SUB_EN to add the 'sub' port.
// When sub=1 the adder computes a + ~b + 1 (a - b).
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous reset, active low
//   in_valid   in   1        operands valid
//   in_ready   out  1        stage 0 can accept this cycle
//   a, b       in   WIDTH    unsigned operands
//   cin        in   1        carry into bit 0
//   sub        in   1        subtract select (U_PCLA_SUB_EN only)
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   sum        out  WIDTH+1  a + b + cin; sum[WIDTH] is the carry out
// ---------------------------------------------------------------------------
module u_pcla #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef U_PCLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int NBLK = WIDTH / BLOCK;

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("u_pcla: WIDTH (%0d) must be a multiple of BLOCK (%0d)", WIDTH, BLOCK);
  end

  // One CLA group: every carry is a flat sum of products of g/p terms and the
  // group carry-in. No carry ripples from bit to bit inside the group.
  // Returns {carry_out, sum_slice}.
  function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             ci);
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    logic             pp;
    // NOTE: blocking assignments are right here; this is pure combinational
    // evaluation, and each line must see the value computed just above it.
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & ci);
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  // Operand conditioning for stage 0.
  logic [WIDTH-1:0] w_b0;
  logic             w_c0;
`ifdef U_PCLA_SUB_EN
  // Subtract is a + ~b + 1. The inverted operand travels down the pipe with
  // its own operation, so later groups need no knowledge of 'sub'.
  assign w_b0 = sub ? ~b : b;
  assign w_c0 = sub | cin;
`else
  assign w_b0 = b;
  assign w_c0 = cin;
`endif

  for (genvar s = 0; s < NBLK; s++) begin : g_stage
    localparam int DONE = (s + 1) * BLOCK;  // result bits known after stage s
    localparam int REM  = WIDTH - DONE;     // operand bits still pending

    logic             w_v_in;
    logic             w_c_in;
    logic             w_ld;
    logic             w_ld_next;
    logic [BLOCK-1:0] w_ga;
    logic [BLOCK-1:0] w_gb;
    logic [BLOCK:0]   w_grp;
    logic [DONE-1:0]  w_sum_nxt;
    logic             r_v;
    logic             r_c;
    logic [DONE-1:0]  r_sum;

    if (s == 0) begin : g_src
      assign w_v_in    = in_valid;
      assign w_c_in    = w_c0;
      assign w_ga      = a[BLOCK-1:0];
      assign w_gb      = w_b0[BLOCK-1:0];
      assign w_sum_nxt = w_grp[BLOCK-1:0];
    end else begin : g_src
      assign w_v_in    = g_stage[s-1].r_v;
      assign w_c_in    = g_stage[s-1].r_c;
      assign w_ga      = g_stage[s-1].g_ops.r_a[BLOCK-1:0];
      assign w_gb      = g_stage[s-1].g_ops.r_b[BLOCK-1:0];
      assign w_sum_nxt = {w_grp[BLOCK-1:0], g_stage[s-1].r_sum};
    end

    assign w_grp = cla_group(w_ga, w_gb, w_c_in);

    if (s == NBLK - 1) begin : g_next
      assign w_ld_next = out_ready;
    end else begin : g_next
      assign w_ld_next = g_stage[s+1].w_ld;
    end

    // A stage loads when it is empty or when its content moves on this cycle.
    // An empty stage therefore fills even while everything below it stalls.
    assign w_ld = !r_v || w_ld_next;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
      end else if (w_ld) begin
        r_v <= w_v_in;
      end
    end

    if (s == NBLK - 1) begin : g_data
      // Output register: sum must read zero out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_c   <= 1'b0;
          r_sum <= '0;
        end else if (w_ld && w_v_in) begin
          r_c   <= w_grp[BLOCK];
          r_sum <= w_sum_nxt;
        end
      end
    end else begin : g_data
      // NOTE: internal data flops carry no reset. Their content is ignored
      // while r_v=0, so a reset would only add routing and area.
      always_ff @(posedge clk) begin
        if (w_ld && w_v_in) begin
          r_c   <= w_grp[BLOCK];
          r_sum <= w_sum_nxt;
        end
      end
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;
      logic [REM-1:0] w_a_in;
      logic [REM-1:0] w_b_in;

      if (s == 0) begin : g_in
        assign w_a_in = a[WIDTH-1:BLOCK];
        assign w_b_in = w_b0[WIDTH-1:BLOCK];
      end else begin : g_in
        assign w_a_in = g_stage[s-1].g_ops.r_a[REM+BLOCK-1:BLOCK];
        assign w_b_in = g_stage[s-1].g_ops.r_b[REM+BLOCK-1:BLOCK];
      end

      // Load only with a valid operation so idle cycles cause no toggling.
      always_ff @(posedge clk) begin
        if (w_ld && w_v_in) begin
          r_a <= w_a_in;
          r_b <= w_b_in;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].w_ld;
  assign out_valid = g_stage[NBLK-1].r_v;
  assign sum       = {g_stage[NBLK-1].r_c, g_stage[NBLK-1].r_sum};

endmodule

// File: tb/tb_u_pcla.sv
// ---------------------------------------------------------------------------
// tb_u_pcla -- scoreboard bench for u_pcla (WIDTH=32, BLOCK=8).
// The driver pushes the expected sum of each operation when it is accepted.
// The monitor pops the queue and compares on every output handshake.
// Inputs change 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_u_pcla;
  localparam int WIDTH = 32;
  localparam int BLOCK = 8;
  localparam int NBLK  = WIDTH / BLOCK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH:0]   sum;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int out_cyc  = 0;
  int n_acc    = 0;
  int n_stall  = 0;
  logic [WIDTH:0] exp_q[$];

  u_pcla #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef U_PCLA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious result: got %h expected no output", sum);
      end else begin
        check("result", 64'(sum), 64'(exp_q.pop_front()));
      end
    end
  end

  // Called at posedge+1. It returns at posedge+1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic tc, input logic ts, input logic [WIDTH:0] texp);
    int budget = 0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 300) begin
      budget++;
      n_stall++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send timeout: got in_ready=0 expected 1 within 300 cycles");
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(texp);
    acc_cyc = cyc;
    n_acc++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    check("drain pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    logic [WIDTH:0]   snap;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    // Single op and latency
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0100);
    drain();
    check("latency", 64'(out_cyc - acc_cyc), 64'(NBLK));

    // Full carry propagation
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 33'h1_0000_0000);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF);
    drain();

    // Back-to-back stream
    n_stall = 0;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc});
    end
    drain();
    check("stream stalls", 64'(n_stall), 64'd0);

    // Backpressure with six ops
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 33'h0_2345_6789);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 33'h0_0001_0001);
        send(32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0, 33'h0_DEAD_BEF0);
        send(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0, 33'h1_0000_0000);
        send(32'h00FF_00FF, 32'hFF00_FF00, 1'b0, 1'b0, 33'h0_FFFF_FFFF);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        snap = sum;
        check("stall out_valid", 64'(out_valid), 64'd1);
        check("stall head sum", 64'(sum), 64'h0_2345_6789);
        repeat (4) @(posedge clk);
        #1;
        check("stall sum stable", 64'(sum), 64'(snap));
        check("stall in_ready", 64'(in_ready), 64'd0);
        check("stall accepted", 64'(n_acc), 64'd4);
        out_ready = 1'b1;
        #1;
        check("full pipe accept+emit", 64'(in_ready), 64'd1);
      end
    join
    drain();
    check("backpressure accepted", 64'(n_acc), 64'd6);

    // Reset with ops in flight
    out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 33'h0_0000_0003);
    send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 33'h0_0000_0031);
    send(32'h0000_000A, 32'h0000_000B, 1'b0, 1'b0, 33'h0_0000_0015);
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset sum", 64'(sum), 64'd0);
    check("async reset in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no stale result", 64'(out_valid), 64'd0);

`ifdef U_PCLA_SUB_EN
    // Subtract: cin is ignored when sub=1
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 33'h0_FFFF_FFFE);
    send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 33'h1_0000_0002);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 33'h0_0000_000D);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
